// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier feeding the HI/LO registers.
// One product bit per cycle; the result lands in HI/LO 33 cycles after the start edge.
module mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_mult,
   input  logic             mult_sign,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             mult_busy,
   output logic             mult_done
);

   typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

   state_t             state_reg;
   logic [WIDTH-1:0]   mcand_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [5:0]         cnt_reg;
   logic               sign_reg;
   logic               msbx_reg;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;
   logic               busy_reg;
   logic               done_reg;

   logic [1:0][WIDTH-1:0] op_vec;
   logic [1:0][WIDTH-1:0] mag_vec;
   logic                  neg;
   logic [WIDTH:0]        sum_next;
   logic [2*WIDTH-1:0]    acc_next;
   logic [2*WIDTH-1:0]    result_next;

   assign op_vec = {op_b, op_a};

   // Signed operands enter the datapath as unsigned magnitudes; -2^(W-1) maps to 2^(W-1).
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_mag
         assign mag_vec[gi] = (mult_sign && op_vec[gi][WIDTH-1])
                              ? (~op_vec[gi] + WIDTH'(1))
                              : op_vec[gi];
      end
   endgenerate

   assign neg = sign_reg & msbx_reg;

   always_comb begin
      sum_next    = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                    + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);
      // The carry out of the add shifts into the top of the accumulator.
      acc_next    = {sum_next, acc_reg[WIDTH-1:1]};
      result_next = neg ? (~acc_reg + (2*WIDTH)'(1)) : acc_reg;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         sign_reg   <= 1'b0;
         msbx_reg   <= 1'b0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start_mult) begin
                  sign_reg   <= mult_sign;
                  msbx_reg   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                  mcand_reg  <= mag_vec[0];
                  mplier_reg <= mag_vec[1];
                  acc_reg    <= '0;
                  cnt_reg    <= '0;
                  busy_reg   <= 1'b1;
                  state_reg  <= CALC;
               end
            end
            CALC: begin
               acc_reg    <= acc_next;
               mplier_reg <= mplier_reg >> 1;
               cnt_reg    <= cnt_reg + 6'd1;
               if (cnt_reg == 6'(WIDTH - 1)) begin
                  state_reg <= WRITE;
               end
            end
            WRITE: begin
               {hi_reg, lo_reg} <= result_next;
               done_reg         <= 1'b1;
               busy_reg         <= 1'b0;
               state_reg        <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign hi        = hi_reg;
   assign lo        = lo_reg;
   assign mult_busy = busy_reg;
   assign mult_done = done_reg;

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: the stimulus queues expected HI/LO pairs,
// a monitor pops and compares them whenever mult_done pulses.
module tb_mult_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_mult = 1'b0;
   logic        mult_sign = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        mult_busy;
   logic        mult_done;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   mult_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start_mult (start_mult),
      .mult_sign  (mult_sign),
      .op_a       (op_a),
      .op_b       (op_b),
      .hi         (hi),
      .lo         (lo),
      .mult_busy  (mult_busy),
      .mult_done  (mult_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued product.
   always @(negedge clk) begin
      if (mult_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got hi=%h lo=%h, expected no result", hi, lo);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("result", {hi, lo}, e);
            $display("result hi=%h lo=%h (expected %h)", hi, lo, e);
         end
      end
   end

   // One multiply; poke=1 drives a spurious start and changes operands mid-CALC.
   task automatic do_mult(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi_e, input logic [31:0] lo_e, input bit poke);
      @(negedge clk);
      mult_sign  = sgn;
      op_a       = a;
      op_b       = b;
      start_mult = 1'b1;
      exp_q.push_back({hi_e, lo_e});
      $display("start sign=%0d a=%h b=%h expect hi=%h lo=%h poke=%0d", sgn, a, b, hi_e, lo_e, poke);
      @(negedge clk);
      start_mult = 1'b0;
      for (int c = 0; c < 33; c++) begin
         chk("busy_during", {63'd0, mult_busy}, 64'd1);
         chk("done_early", {63'd0, mult_done}, 64'd0);
         chk("hilo_hold", {hi, lo}, {last_hi, last_lo});
         if (poke && c == 5) begin
            start_mult = 1'b1;
            op_a       = 32'd7;
            op_b       = 32'd7;
            mult_sign  = ~sgn;
         end else if (poke && c == 6) begin
            start_mult = 1'b0;
            op_a       = 32'h0001_2345;
            op_b       = 32'h0006_789A;
         end
         @(negedge clk);
      end
      chk("busy_end", {63'd0, mult_busy}, 64'd0);
      chk("done_pulse", {63'd0, mult_done}, 64'd1);
      last_hi = hi_e;
      last_lo = lo_e;
      @(negedge clk);
      chk("done_once", {63'd0, mult_done}, 64'd0);
      chk("busy_idle", {63'd0, mult_busy}, 64'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_hilo", {hi, lo}, 64'd0);
      chk("reset_busy", {63'd0, mult_busy}, 64'd0);
      chk("reset_done", {63'd0, mult_done}, 64'd0);
      reset_n = 1'b1;

      do_mult(1'b0, 32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F, 1'b0);
      do_mult(1'b1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      do_mult(1'b0, 32'hFFFF_FFFD, 32'd5,         32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
      do_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      do_mult(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      do_mult(1'b1, 32'h8000_0000, 32'd1,         32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      do_mult(1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0);
      do_mult(1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b1);
      // A few idle cycles after the poked run: no second busy period.
      repeat (3) begin
         @(negedge clk);
         chk("no_second_busy", {63'd0, mult_busy}, 64'd0);
      end

      // Reset at E10 of a 3x5 multiply.
      do_mult(1'b0, 32'd3, 32'd5, 32'h0, 32'hF, 1'b0);
      @(negedge clk);
      mult_sign  = 1'b0;
      op_a       = 32'd3;
      op_b       = 32'd5;
      start_mult = 1'b1;
      $display("start sign=0 a=%h b=%h then reset at E10", op_a, op_b);
      @(negedge clk);
      start_mult = 1'b0;
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midreset_hilo", {hi, lo}, 64'd0);
      chk("midreset_busy", {63'd0, mult_busy}, 64'd0);
      chk("midreset_done", {63'd0, mult_done}, 64'd0);
      reset_n = 1'b1;
      last_hi = '0;
      last_lo = '0;
      repeat (30) begin
         @(negedge clk);
         if (mult_done !== 1'b0 || mult_busy !== 1'b0) begin
            chk("post_reset_quiet", {62'd0, mult_busy, mult_done}, 64'd0);
         end
      end
      do_mult(1'b0, 32'd2, 32'd2, 32'h0, 32'h4, 1'b0);

      // Hold behaviour: 3x5 then 2x2, HI/LO stay 0/F until the second write.
      do_mult(1'b0, 32'd3, 32'd5, 32'h0, 32'hF, 1'b0);
      do_mult(1'b0, 32'd2, 32'd2, 32'h0, 32'h4, 1'b0);

      repeat (2) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit, expected completion");
      $fatal(1, "timeout");
   end

endmodule
